// File: rtl/nn_feeder_pkg.sv
// Shared definitions for the neural-network frame feeder.
//   state_e       : feeder FSM states
//   NB            : bytes per frame at the default geometry
//   TIMEOUT_CLASS : class code reported when the network never signals done
package nn_feeder_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    LABEL,
    LOAD,
    WAIT,
    RESULT
  } state_e;

  localparam int unsigned DEF_IMAGE_BITS = 256;
  localparam int unsigned DEF_BYTE_WIDTH = 8;
  localparam int unsigned NB             = DEF_IMAGE_BITS / DEF_BYTE_WIDTH;
  localparam logic [3:0]  TIMEOUT_CLASS  = 4'hF;

endpackage

// File: rtl/nn_frame_assembler.sv
// Byte-to-vector assembler. Byte k of a frame is written to
// image_o[k*BYTE_WIDTH +: BYTE_WIDTH]; the counter wraps after the last byte.
//   clk, reset         : clock, async active-high reset
//   wr_en_i            : accept data_i this cycle
//   data_i             : image byte
//   frame_complete_o   : current write is the last byte of the frame
//   cnt_zero_o         : byte counter is at the start of a frame
//   image_o            : assembled image vector (held until overwritten)
module nn_frame_assembler #(
  parameter int unsigned IMAGE_BITS = 256,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [BYTE_WIDTH-1:0] data_i,
  output logic                  frame_complete_o,
  output logic                  cnt_zero_o,
  output logic [IMAGE_BITS-1:0] image_o
);

  localparam int unsigned NBY = IMAGE_BITS / BYTE_WIDTH;
  localparam int unsigned CW  = (NBY > 1) ? $clog2(NBY) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBY - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IMAGE_BITS-1:0] image_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      image_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en_i) begin
        image_q[cnt_q*BYTE_WIDTH +: BYTE_WIDTH] <= data_i;
      end
    end
  end

  assign frame_complete_o = wr_en_i && (cnt_q == LAST);
  assign cnt_zero_o       = (cnt_q == '0);
  assign image_o          = image_q;

endmodule

// File: rtl/nn_frame_feeder.sv
// Front end for the neural-network classifier: collects an image byte
// stream, pulses nn_load, waits for a rising nn_done (or a timeout) and
// returns the class over a valid/ready handshake.
// Optional feature macro: SCORE_EN (label byte per frame plus
// correct_count/total_count scoring counters).
//   clk, reset                  : clock, async active-high reset
//   in_data/in_valid/in_ready   : image byte stream (label byte with SCORE_EN)
//   nn_input, nn_load           : vector and start pulse to the network
//   nn_done, nn_max             : completion and class from the network
//   result_class/_timeout/_valid/_ready : result handshake
//   busy                        : high unless idle at the start of a frame
//   correct_count, total_count  : scoring counters (SCORE_EN only)
module nn_frame_feeder
  import nn_feeder_pkg::*;
#(
  parameter int unsigned IMAGE_BITS     = DEF_IMAGE_BITS,
  parameter int unsigned BYTE_WIDTH     = DEF_BYTE_WIDTH,
  parameter int unsigned CLASS_BITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [IMAGE_BITS-1:0] nn_input,
  output logic                  nn_load,
  input  logic                  nn_done,
  input  logic [CLASS_BITS-1:0] nn_max,
  output logic [CLASS_BITS-1:0] result_class,
  output logic                  result_timeout,
  output logic                  result_valid,
  input  logic                  result_ready,
`ifdef SCORE_EN
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  total_count,
`endif
  output logic                  busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic                  in_ready_q;
  logic                  nn_load_q;
  logic [TW-1:0]         timer_q;
  logic                  done_prev_q;
  logic [CLASS_BITS-1:0] result_class_q;
  logic                  result_timeout_q;
  logic                  result_valid_q;
`ifdef SCORE_EN
  logic [CLASS_BITS-1:0] label_q;
  logic [CNT_WIDTH-1:0]  correct_q;
  logic [CNT_WIDTH-1:0]  total_q;
`endif

  logic byte_wr;
  logic frame_complete;
  logic cnt_zero;
  logic done_rise;

  // Only image bytes reach the assembler; the label byte is captured here.
  assign byte_wr   = in_valid && in_ready_q && (state_q == COLLECT);
  assign done_rise = nn_done && !done_prev_q;

  nn_frame_assembler #(
    .IMAGE_BITS (IMAGE_BITS),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_assembler (
    .clk              (clk),
    .reset            (reset),
    .wr_en_i          (byte_wr),
    .data_i           (in_data),
    .frame_complete_o (frame_complete),
    .cnt_zero_o       (cnt_zero),
    .image_o          (nn_input)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= COLLECT;
      in_ready_q       <= 1'b0;
      nn_load_q        <= 1'b0;
      timer_q          <= '0;
      done_prev_q      <= 1'b0;
      result_class_q   <= '0;
      result_timeout_q <= 1'b0;
      result_valid_q   <= 1'b0;
`ifdef SCORE_EN
      label_q          <= '0;
      correct_q        <= '0;
      total_q          <= '0;
`endif
    end else begin
      done_prev_q <= nn_done;
      case (state_q)
        COLLECT: begin
          in_ready_q <= 1'b1;
          if (frame_complete) begin
`ifdef SCORE_EN
            state_q    <= LABEL;
`else
            state_q    <= LOAD;
            nn_load_q  <= 1'b1;
            in_ready_q <= 1'b0;
`endif
          end
        end
        LABEL: begin
`ifdef SCORE_EN
          if (in_valid && in_ready_q) begin
            label_q    <= in_data[CLASS_BITS-1:0];
            state_q    <= LOAD;
            nn_load_q  <= 1'b1;
            in_ready_q <= 1'b0;
          end
`else
          state_q <= COLLECT;
`endif
        end
        LOAD: begin
          nn_load_q <= 1'b0;
          timer_q   <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          // A done edge wins over a timeout landing in the same cycle.
          if (done_rise) begin
            result_class_q   <= nn_max;
            result_timeout_q <= 1'b0;
            result_valid_q   <= 1'b1;
            state_q          <= RESULT;
          end else if (timer_q == TIMER_LAST) begin
            result_class_q   <= CLASS_BITS'(TIMEOUT_CLASS);
            result_timeout_q <= 1'b1;
            result_valid_q   <= 1'b1;
            state_q          <= RESULT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESULT: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            in_ready_q     <= 1'b1;
            state_q        <= COLLECT;
`ifdef SCORE_EN
            if (total_q != '1) begin
              total_q <= total_q + 1'b1;
            end
            if (!result_timeout_q && (result_class_q == label_q) && (correct_q != '1)) begin
              correct_q <= correct_q + 1'b1;
            end
`endif
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign nn_load        = nn_load_q;
  assign result_class   = result_class_q;
  assign result_timeout = result_timeout_q;
  assign result_valid   = result_valid_q;
  assign busy           = (state_q != COLLECT) || !cnt_zero;
`ifdef SCORE_EN
  assign correct_count  = correct_q;
  assign total_count    = total_q;
`endif

endmodule

// File: tb/tb_nn_frame_feeder.sv
// Directed self-checking bench for nn_frame_feeder.
module tb_nn_frame_feeder;
  import nn_feeder_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] nn_input;
  logic         nn_load;
  logic         nn_done;
  logic [3:0]   nn_max;
  logic [3:0]   result_class;
  logic         result_timeout;
  logic         result_valid;
  logic         result_ready;
  logic         busy;
`ifdef SCORE_EN
  logic [15:0]  correct_count;
  logic [15:0]  total_count;
`endif

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  nn_frame_feeder #(
    .IMAGE_BITS     (256),
    .BYTE_WIDTH     (8),
    .CLASS_BITS     (4),
    .TIMEOUT_CYCLES (4096),
    .CNT_WIDTH      (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .nn_input       (nn_input),
    .nn_load        (nn_load),
    .nn_done        (nn_done),
    .nn_max         (nn_max),
    .result_class   (result_class),
    .result_timeout (result_timeout),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
`ifdef SCORE_EN
    .correct_count  (correct_count),
    .total_count    (total_count),
`endif
    .busy           (busy)
  );

  always @(negedge clk) begin
    if (nn_load === 1'b1) load_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_vec(input logic [7:0] base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < int'(NB); i++) v[8*i +: 8] = 8'(base + 8'(i));
    return v;
  endfunction

  // Streams one frame with in_valid held high; the final tick is the last
  // accepted byte (label byte when scoring is built in).
  task automatic send_frame(input logic [7:0] base, input logic [3:0] label, input string tag);
    int stalls;
    stalls = 0;
    for (int i = 0; i < int'(NB); i++) begin
      in_data  = 8'(base + 8'(i));
      in_valid = 1'b1;
      if (in_ready !== 1'b1) stalls++;
      tick();
    end
`ifdef SCORE_EN
    in_data = {4'h0, label};
    if (in_ready !== 1'b1) stalls++;
    tick();
`else
    if (label === 4'hx) stalls++;
`endif
    in_valid = 1'b0;
    check({tag, "_stall"}, 256'(stalls), 256'd0);
  endtask

  initial begin
    logic [255:0] exp1, exp2, exp3;
    int bad;
    int cnt;
    logic [3:0] lbl [3];
    logic [3:0] mx  [3];

    reset = 1'b1; in_data = '0; in_valid = 1'b0; nn_done = 1'b0;
    nn_max = '0; result_ready = 1'b0;
    exp1 = exp_vec(8'h01);
    exp2 = exp_vec(8'h40);
    exp3 = exp_vec(8'hC0);

    // Reset state
    tick(); tick();
    check("rst_input", nn_input, '0);
    check("rst_ready", 256'(in_ready), 256'd0);
    check("rst_load", 256'(nn_load), 256'd0);
    check("rst_valid", 256'(result_valid), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_class", 256'(result_class), 256'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", 256'(in_ready), 256'd1);

    // Frame 1: bytes 0x01..0x20, done after 50 cycles with class 7
    send_frame(8'h01, 4'd7, "f1");
    check("f1_load", 256'(nn_load), 256'd1);
    check("f1_ready_low", 256'(in_ready), 256'd0);
    check("f1_busy", 256'(busy), 256'd1);
    check("f1_byte0", 256'(nn_input[7:0]), 256'h01);
    check("f1_byte31", 256'(nn_input[255:248]), 256'h20);
    check("f1_vec", nn_input, exp1);
    in_data = 8'hAA; in_valid = 1'b1;
    tick();
    check("f1_load_pulse", 256'(nn_load), 256'd0);
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      if (in_ready !== 1'b0 || result_valid !== 1'b0) bad++;
      tick();
    end
    check("f1_wait_quiet", 256'(bad), 256'd0);
    nn_done = 1'b1; nn_max = 4'd7;
    tick();
    check("f1_valid", 256'(result_valid), 256'd1);
    check("f1_class", 256'(result_class), 256'd7);
    check("f1_tmo", 256'(result_timeout), 256'd0);
    nn_max = 4'd9;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid !== 1'b1 || result_class !== 4'd7 || result_timeout !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    check("f1_hold", 256'(bad), 256'd0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("f1_hs_valid", 256'(result_valid), 256'd0);
    check("f1_hs_ready", 256'(in_ready), 256'd1);
    check("f1_no_aa", nn_input, exp1);
    check("f1_idle_busy", 256'(busy), 256'd0);
    in_valid = 1'b0;
    check("f1_loads", 256'(load_cnt), 256'd1);

    // Frame 2: nn_done left high, never re-rises -> timeout
    send_frame(8'h40, 4'd4, "f2");
    check("f2_vec", nn_input, exp2);
    cnt = 0;
    while (result_valid !== 1'b1 && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("f2_tmo_cycles", 256'(cnt), 256'd4097);
    check("f2_class", 256'(result_class), 256'hF);
    check("f2_tmo", 256'(result_timeout), 256'd1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    nn_done = 1'b0;
    check("f2_hs_valid", 256'(result_valid), 256'd0);
    check("f2_loads", 256'(load_cnt), 256'd2);

    // Async reset after 17 bytes of an aborted frame
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(8'h80 + 8'(i)); in_valid = 1'b1;
      tick();
    end
    #3 reset = 1'b1;
    #1;
    check("ar_input", nn_input, '0);
    check("ar_ready", 256'(in_ready), 256'd0);
    check("ar_busy", 256'(busy), 256'd0);
    check("ar_load", 256'(nn_load), 256'd0);
`ifdef SCORE_EN
    check("ar_total", 256'(total_count), 256'd0);
`endif
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    check("ar_loads", 256'(load_cnt), 256'd2);
    send_frame(8'hC0, 4'd2, "f3");
    check("f3_load", 256'(nn_load), 256'd1);
    check("f3_vec", nn_input, exp3);
    tick();
    check("f3_loads", 256'(load_cnt), 256'd3);
    tick(); tick();
    nn_done = 1'b1; nn_max = 4'd2;
    tick();
    check("f3_valid", 256'(result_valid), 256'd1);
    check("f3_class", 256'(result_class), 256'd2);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0; nn_done = 1'b0;
    tick();
    check("f3_idle", 256'(busy), 256'd0);

`ifdef SCORE_EN
    // Scoring: labels 3,5,9 against network classes 3,5,2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("sc_rst_total", 256'(total_count), 256'd0);
    check("sc_rst_correct", 256'(correct_count), 256'd0);
    lbl[0] = 4'd3; lbl[1] = 4'd5; lbl[2] = 4'd9;
    mx[0]  = 4'd3; mx[1]  = 4'd5; mx[2]  = 4'd2;
    for (int f = 0; f < 3; f++) begin
      send_frame(8'(8'h10 + 8'(f * 32)), lbl[f], "sc");
      tick(); tick();
      nn_done = 1'b1; nn_max = mx[f];
      tick();
      check("sc_valid", 256'(result_valid), 256'd1);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0; nn_done = 1'b0;
      tick();
    end
    check("sc_total", 256'(total_count), 256'd3);
    check("sc_correct", 256'(correct_count), 256'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
